// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register decode and default sizing.
package gpio_pkg;

  // addr[0] selects which register of a set is accessed
  localparam logic REG_DIR  = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int DEF_NUM_GPIO_SETS = 4;
  localparam int DEF_GPIO_WIDTH    = 8;

  // Address width: one bit of register select plus the set index.
  function automatic int gpio_addr_w(input int num_sets);
    return $clog2(num_sets) + 1;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Register bus between a master and the GPIO bank.
interface gpio_bank_if #(
  parameter int AW = 3,
  parameter int W  = 8
);
  logic [AW-1:0] addr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;

  modport master (output addr, output wr_en, output wr_data, input rd_data);
  modport slave  (input addr, input wr_en, input wr_data, output rd_data);
endinterface

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for pad inputs that are asynchronous to clk.
module gpio_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync1_d, sync1_q;
  logic [W-1:0] sync2_d, sync2_q;

  // chain advances one stage per cycle
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // async clear, shift on every rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;
endmodule

// File: rtl/gpio_bank.sv
// Bank of GPIO sets: per-set DIR and DATA registers, synchronized pad
// readback and a registered read mux. Pad drivers use gpio_out/gpio_oe.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NUM_GPIO_SETS = DEF_NUM_GPIO_SETS,
  parameter int GPIO_WIDTH    = DEF_GPIO_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  gpio_bank_if.slave                          bus,
  input  logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0] gpio_in,
  output logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0] gpio_out,
  output logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0] gpio_oe
);
  localparam int AW = gpio_addr_w(NUM_GPIO_SETS);

  logic [NUM_GPIO_SETS-1:0][GPIO_WIDTH-1:0] dir_d, dir_q;
  logic [NUM_GPIO_SETS-1:0][GPIO_WIDTH-1:0] out_d, out_q;
  logic [NUM_GPIO_SETS-1:0][GPIO_WIDTH-1:0] pad_q;
  logic [GPIO_WIDTH-1:0]                    rd_d, rd_q;

  logic [AW-1:0] addr_w;
  logic          reg_sel;
  int            set_idx;

  assign addr_w  = bus.addr;
  assign reg_sel = addr_w[0];
  // out-of-range indices match no set below, so writes drop and reads give 0
  assign set_idx = int'(addr_w >> 1);

  for (genvar g = 0; g < NUM_GPIO_SETS; g++) begin : g_sync
    gpio_sync2 #(.W(GPIO_WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gpio_in[g*GPIO_WIDTH +: GPIO_WIDTH]),
      .q   (pad_q[g])
    );
  end

  // register writes: whole word latched, direction only gates the pad driver
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    for (int s = 0; s < NUM_GPIO_SETS; s++) begin
      if (bus.wr_en && set_idx == s) begin
        if (reg_sel == REG_DIR) dir_d[s] = bus.wr_data;
        else                    out_d[s] = bus.wr_data;
      end
    end
  end

  // read mux from current state, so a same-cycle write shows up one cycle later
  always_comb begin
    rd_d = '0;
    for (int s = 0; s < NUM_GPIO_SETS; s++) begin
      if (set_idx == s) begin
        if (reg_sel == REG_DIR) rd_d = dir_q[s];
        else rd_d = (dir_q[s] & out_q[s]) | (~dir_q[s] & pad_q[s]);
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= '0;
      out_q <= '0;
      rd_q  <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.rd_data = rd_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed test-plan checks plus a
// randomized phase compared every cycle against a behavioural model.
module tb_gpio_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  a_r  = '0;
  logic        we_r = 1'b0;
  logic [7:0]  wd_r = '0;
  logic [31:0] pin  = '0;

  logic [31:0] gpio_out, gpio_oe;
  logic [23:0] gpio_out3, gpio_oe3;

  gpio_bank_if #(.AW(3), .W(8)) bus ();
  gpio_bank_if #(.AW(3), .W(8)) bus3 ();
  assign bus.addr  = a_r;  assign bus.wr_en  = we_r; assign bus.wr_data  = wd_r;
  assign bus3.addr = a_r;  assign bus3.wr_en = we_r; assign bus3.wr_data = wd_r;

  gpio_bank #(.NUM_GPIO_SETS(4), .GPIO_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .gpio_in(pin), .gpio_out(gpio_out), .gpio_oe(gpio_oe));

  // non-power-of-2 bank: addresses 6 and 7 are out of range
  gpio_bank #(.NUM_GPIO_SETS(3), .GPIO_WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .gpio_in(pin[23:0]), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register values per set and the pad values seen at
  // the last two rising edges (readback uses the older one).
  logic [7:0]  dir_m [4] = '{default: '0};
  logic [7:0]  out_m [4] = '{default: '0};
  logic [31:0] pad_new = '0, pad_old = '0;
  logic [7:0]  exp_rd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 4; s++) begin dir_m[s] = '0; out_m[s] = '0; end
      pad_new = '0; pad_old = '0; exp_rd = '0;
    end else begin
      int s;
      s = int'(a_r) / 2;
      if (a_r % 2 == 0) exp_rd = dir_m[s];
      else begin
        for (int b = 0; b < 8; b++)
          exp_rd[b] = dir_m[s][b] ? out_m[s][b] : pad_old[s*8+b];
      end
      if (we_r) begin
        if (a_r % 2 == 0) dir_m[s] = wd_r;
        else              out_m[s] = wd_r;
      end
      pad_old = pad_new;
      pad_new = pin;
    end
  end

  // every-cycle comparison of the main DUT against the model
  always @(negedge clk) begin
    chk("rd_data", {24'h0, bus.rd_data}, {24'h0, exp_rd});
    chk("gpio_out", gpio_out, {out_m[3], out_m[2], out_m[1], out_m[0]});
    chk("gpio_oe",  gpio_oe,  {dir_m[3], dir_m[2], dir_m[1], dir_m[0]});
  end

  // drive one bus cycle, return at the following falling edge
  task automatic step(input logic [2:0] a, input logic we, input logic [7:0] d);
    a_r = a; we_r = we; wd_r = d;
    @(posedge clk);
    @(negedge clk);
    we_r = 1'b0;
  endtask

  logic [7:0] rdv;

  initial begin
    // reset held for two cycles
    step(0, 0, 0); step(0, 0, 0);
    chk("rst_rd", {24'h0, bus.rd_data}, 32'h0);
    chk("rst_oe", gpio_oe, 32'h0);
    chk("rst_out", gpio_out, 32'h0);
    rst = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(3'(2*s), 0, 0);
      chk("rst_dir_read", {24'h0, bus.rd_data}, 32'h0);
    end

    // all outputs
    step(0, 1, 8'hFF); step(2, 1, 8'hFF); step(4, 1, 8'hFF); step(6, 1, 8'hFF);
    step(1, 1, 8'h24); step(3, 1, 8'h81); step(5, 1, 8'h09); step(7, 1, 8'h63);
    chk("all_out_oe", gpio_oe, 32'hFFFF_FFFF);
    chk("all_out_val", gpio_out, 32'h6309_8124);
    step(3, 0, 0);
    chk("read_addr3", {24'h0, bus.rd_data}, 32'h81);

    // switch to inputs
    pin = 32'hA5C3_F00F;
    step(0, 1, 0); step(2, 1, 0); step(4, 1, 0); step(6, 1, 0);
    chk("inputs_oe", gpio_oe, 32'h0);
    step(1, 0, 0); step(1, 0, 0);
    step(1, 0, 0); chk("in_set0", {24'h0, bus.rd_data}, 32'h0F);
    step(3, 0, 0); chk("in_set1", {24'h0, bus.rd_data}, 32'hF0);
    step(5, 0, 0); chk("in_set2", {24'h0, bus.rd_data}, 32'hC3);
    step(7, 0, 0); chk("in_set3", {24'h0, bus.rd_data}, 32'hA5);
    chk("inputs_out_kept", gpio_out, 32'h6309_8124);

    // mixed direction on set 0
    pin[7:0] = 8'h55;
    step(0, 1, 8'hF0); step(1, 1, 8'hAA); step(1, 0, 0);
    chk("mixed_dir", {24'h0, bus.rd_data}, 32'hA5);

    // synchronizer latency: bit 0 is an input currently at 1
    pin[0] = 1'b0;
    step(1, 0, 0); rdv = bus.rd_data; chk("sync_edge1", {31'h0, rdv[0]}, 32'h1);
    step(1, 0, 0); rdv = bus.rd_data; chk("sync_edge2", {31'h0, rdv[0]}, 32'h1);
    step(1, 0, 0); rdv = bus.rd_data; chk("sync_edge3", {31'h0, rdv[0]}, 32'h0);

    // read during write returns the old value, new value next cycle
    step(2, 1, 8'h3C); chk("rdw_old", {24'h0, bus.rd_data}, 32'h00);
    step(2, 0, 0);     chk("rdw_new", {24'h0, bus.rd_data}, 32'h3C);

    // asynchronous reset in the middle of the high phase
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rd", {24'h0, bus.rd_data}, 32'h0);
    chk("async_out", gpio_out, 32'h0);
    chk("async_oe", gpio_oe, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // three-set bank: out-of-range writes ignored and read as zero
    step(6, 1, 8'hFF); chk("oor_oe_dir", {8'h0, gpio_oe3}, 32'h0);
    step(7, 1, 8'hFF); chk("oor_out", {8'h0, gpio_out3}, 32'h0);
    chk("oor_rd_dir", {24'h0, bus3.rd_data}, 32'h0);
    step(6, 0, 0); chk("oor_rd_data", {24'h0, bus3.rd_data}, 32'h0);
    step(4, 1, 8'h5A); chk("set2_oe", {8'h0, gpio_oe3}, 32'h005A_0000);
    step(4, 0, 0); chk("set2_rd", {24'h0, bus3.rd_data}, 32'h5A);

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pin = $urandom;
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
